// File: rtl/serial_adder_ctrl_if.sv
// rtl/serial_adder_ctrl_if.sv - request/result handshake bundle for serial_adder_ctrl
//
// Purpose : groups the operand request channel, the result channel and the
//           busy status of the bit-serial adder into one interface.
// Optional: SERIAL_ADDER_SUB_EN adds the 1-bit 'sub' request field.
// Signals :
//   in_valid / in_ready   request handshake (requester -> controller)
//   a, b [WIDTH]          operands, cin carry-in, sub (optional) subtract select
//   out_valid / out_ready result handshake (controller -> consumer)
//   sum [WIDTH], cout     result, busy high while the adder is running
// Modports: master = requester/consumer side, slave = controller side.

interface serial_adder_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
`ifdef SERIAL_ADDER_SUB_EN
    logic             sub;
`endif
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             busy;

    modport master (
        output in_valid,
        output a,
        output b,
        output cin,
`ifdef SERIAL_ADDER_SUB_EN
        output sub,
`endif
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  sum,
        input  cout,
        input  busy
    );

    modport slave (
        input  in_valid,
        input  a,
        input  b,
        input  cin,
`ifdef SERIAL_ADDER_SUB_EN
        input  sub,
`endif
        input  out_ready,
        output in_ready,
        output out_valid,
        output sum,
        output cout,
        output busy
    );
endinterface

// File: rtl/serial_adder_ctrl.sv
// rtl/serial_adder_ctrl.sv - bit-serial WIDTH-bit adder controller around one NAND full adder
//
// Purpose : time-shares a single full_adder_nand cell over WIDTH cycles, LSB
//           first, computing {cout,sum} = a + b + cin.
// Optional: SERIAL_ADDER_SUB_EN adds bus.sub; when set, b is inverted on
//           capture and the carry loads 1 (a - b, cout=1 means no borrow).
// Ports   :
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    serial_adder_ctrl_if.slave: in_valid/in_ready/a/b/cin[/sub],
//          out_valid/out_ready/sum/cout, busy
// Latency : accept at edge E, out_valid high after edge E+WIDTH.

module full_adder_nand (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);
    logic n1, n2, n3, x, n4, n5, n6;

    // Classic nine-NAND full adder: first half builds a^b, second half adds cin.
    assign n1   = ~(a & b);
    assign n2   = ~(a & n1);
    assign n3   = ~(b & n1);
    assign x    = ~(n2 & n3);
    assign n4   = ~(x & cin);
    assign n5   = ~(x & n4);
    assign n6   = ~(cin & n4);
    assign s    = ~(n5 & n6);
    assign cout = ~(n1 & n4);
endmodule

module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    serial_adder_ctrl_if.slave   bus
);
    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;

    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] sum_sh;
    logic [WIDTH-1:0] sum_q;
    logic             carry;
    logic             cout_q;
    logic [CW-1:0]    cnt;

    logic             fa_s;
    logic             fa_co;
    logic             accept;
    logic             last_bit;
    logic             in_ready_c;
    logic             out_valid_c;
    logic             busy_c;
    logic [WIDTH:0]   sum_cat;

    logic [WIDTH-1:0] b_cap;
    logic             c_cap;

    full_adder_nand u_fa (
        .a    (a_sh[0]),
        .b    (b_sh[0]),
        .cin  (carry),
        .s    (fa_s),
        .cout (fa_co)
    );

    // New sum bit enters at the MSB; the [WIDTH:1] slice also works for WIDTH=1.
    assign sum_cat = {fa_s, sum_sh};

`ifdef SERIAL_ADDER_SUB_EN
    // Two's-complement subtract: a + ~b + 1.
    always_comb begin
        b_cap = bus.sub ? ~bus.b : bus.b;
        c_cap = bus.sub ? 1'b1   : bus.cin;
    end
`else
    always_comb begin
        b_cap = bus.b;
        c_cap = bus.cin;
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        accept      = 1'b0;
        last_bit    = 1'b0;
        in_ready_c  = 1'b0;
        out_valid_c = 1'b0;
        busy_c      = 1'b0;
        case (state)
            IDLE: begin
                in_ready_c = rst_n;
                if (bus.in_valid) begin
                    accept    = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                busy_c = 1'b1;
                if (cnt == CW'(WIDTH - 1)) begin
                    last_bit  = 1'b1;
                    state_nxt = DONE;
                end
            end
            DONE: begin
                out_valid_c = 1'b1;
                if (bus.out_ready) begin
                    // Consuming the result frees the adder in the same cycle,
                    // so a waiting request can be taken back-to-back.
                    in_ready_c = rst_n;
                    if (bus.in_valid) begin
                        accept    = 1'b1;
                        state_nxt = RUN;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh   <= '0;
            b_sh   <= '0;
            sum_sh <= '0;
            sum_q  <= '0;
            carry  <= 1'b0;
            cout_q <= 1'b0;
            cnt    <= '0;
        end else if (accept) begin
            a_sh  <= bus.a;
            b_sh  <= b_cap;
            carry <= c_cap;
            cnt   <= '0;
        end else if (state == RUN) begin
            a_sh   <= a_sh >> 1;
            b_sh   <= b_sh >> 1;
            sum_sh <= sum_cat[WIDTH:1];
            carry  <= fa_co;
            cnt    <= cnt + CW'(1);
            // Result registers change only when an operation completes, so
            // the previous result stays visible through IDLE and the next RUN.
            if (last_bit) begin
                sum_q  <= sum_cat[WIDTH:1];
                cout_q <= fa_co;
            end
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = out_valid_c;
    assign bus.busy      = busy_c;
    assign bus.sum       = sum_q;
    assign bus.cout      = cout_q;
endmodule
